// File: rtl/ram_port_arbiter.sv
// Two-port arbiter and sequencer in front of a single-port 32x16 RAM.
// It accepts one request at a time from the fetch port (p0) or the data port (p1).
// When both ports ask at once, the grant goes round-robin.
// Each transaction drives the RAM for one cycle and captures the registered read data.
// It then pulses a one-cycle response on the port that issued the request.
module ram_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_write,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_write,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // rr_last remembers the most recent winner so a conflict goes to the other port
    logic              rr_last;
    logic              grant0;
    logic              grant1;
    logic              lat_port;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    // The RAM pins come straight from the latched request, so they hold between transactions
    assign ram_address = lat_addr;
    assign ram_data_in = lat_wdata;
    assign busy        = (state != IDLE);

    // Round-robin choice: a lone requester always wins, a tie goes to the port that did not win last
    always_comb begin
        grant0 = p0_req_valid & (~p1_req_valid | rr_last);
        grant1 = p1_req_valid & (~p0_req_valid | ~rr_last);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, combinational ready, and a write strobe that is forced low while reset is high
    always_comb begin
        next_state       = state;
        p0_req_ready     = 1'b0;
        p1_req_ready     = 1'b0;
        ram_write_enable = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    p0_req_ready = grant0;
                    p1_req_ready = grant1;
                end
                if (grant0 | grant1) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                ram_write_enable = lat_write & ~reset;
                next_state       = CAPTURE;
            end
            CAPTURE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the accepted request and record the winner for the next conflict
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last   <= 1'b1;
            lat_port  <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (p0_req_ready | p1_req_ready) begin
            rr_last   <= p1_req_ready;
            lat_port  <= p1_req_ready;
            lat_write <= p1_req_ready ? p1_req_write : p0_req_write;
            lat_addr  <= p1_req_ready ? p1_req_addr  : p0_req_addr;
            lat_wdata <= p1_req_ready ? p1_req_wdata : p0_req_wdata;
        end
    end

    // Capture the RAM output into the owning port's response register and pulse its valid
    always_ff @(posedge clock) begin
        if (reset) begin
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p0_rsp_rdata <= '0;
            p1_rsp_rdata <= '0;
        end else begin
            p0_rsp_valid <= (state == CAPTURE) & ~lat_port;
            p1_rsp_valid <= (state == CAPTURE) & lat_port;
            if ((state == CAPTURE) && !lat_port) begin
                p0_rsp_rdata <= lat_write ? '0 : ram_data_out;
            end
            if ((state == CAPTURE) && lat_port) begin
                p1_rsp_rdata <= lat_write ? '0 : ram_data_out;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter. It runs directed scenarios and then a randomized request stream.
// A small RAM model is attached to the RAM pins.
// Expected behaviour comes from a transaction-level model that tracks acceptance time,
// round-robin order and memory contents.
module tb_ram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        p0_req_valid, p0_req_ready, p0_req_write, p0_rsp_valid;
    logic [4:0]  p0_req_addr;
    logic [15:0] p0_req_wdata, p0_rsp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_write, p1_rsp_valid;
    logic [4:0]  p1_req_addr;
    logic [15:0] p1_req_wdata, p1_rsp_rdata;
    logic        ram_write_enable;
    logic [4:0]  ram_address;
    logic [15:0] ram_data_in;
    logic [15:0] ram_data_out = 16'h0;
    logic        busy;

    logic [15:0] ram_mem [32] = '{default: 16'h0};

    int tests = 0;
    int failures = 0;
    int cyc = 0;

    // Requester-side holding registers: a request stays put until accepted or dropped
    logic        hold_v [2] = '{1'b0, 1'b0};
    logic        hold_w [2];
    logic [4:0]  hold_a [2];
    logic [15:0] hold_d [2];

    // Reference model state
    logic [15:0] ref_mem [32] = '{default: 16'h0};
    bit          m_inflight = 1'b0;
    int          m_acc = 0;
    int          m_port = 0;
    logic        m_write = 1'b0;
    logic [4:0]  m_addr = 5'd0;
    logic [15:0] m_wdata = 16'h0;
    logic [15:0] m_rd = 16'h0;
    bit          m_rr_last = 1'b1;
    logic [15:0] m_exp_rdata [2] = '{16'h0, 16'h0};
    logic [4:0]  m_ram_addr = 5'd0;
    logic [15:0] m_ram_wdata = 16'h0;

    ram_port_arbiter #(.ADDR_W(5), .DATA_W(16)) dut (
        .clock(clock), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .ram_write_enable(ram_write_enable), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
    );

    always #5 clock = ~clock;

    // Single-port RAM with a registered read; a read in the same cycle as a write returns the old word
    always @(posedge clock) begin
        if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
        ram_data_out <= ram_mem[ram_address];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic setReq(input int p, input logic w, input logic [4:0] a, input logic [15:0] d);
        hold_v[p] = 1'b1;
        hold_w[p] = w;
        hold_a[p] = a;
        hold_d[p] = d;
    endtask

    // One clock cycle: drive the held requests, compare every output with the model, advance the model
    task automatic applyStimulus(input logic rst);
        int   age;
        int   p;
        logic e_busy, e_r0, e_r1, e_we, e_rsp0, e_rsp1;
        @(posedge clock);
        #1;
        reset        = rst;
        p0_req_valid = hold_v[0]; p0_req_write = hold_w[0];
        p0_req_addr  = hold_a[0]; p0_req_wdata = hold_d[0];
        p1_req_valid = hold_v[1]; p1_req_write = hold_w[1];
        p1_req_addr  = hold_a[1]; p1_req_wdata = hold_d[1];
        @(negedge clock);

        age    = m_inflight ? (cyc - m_acc) : 99;
        e_busy = m_inflight && (age == 1 || age == 2);
        e_r0   = !rst && !e_busy && hold_v[0] && (!hold_v[1] || m_rr_last);
        e_r1   = !rst && !e_busy && hold_v[1] && (!hold_v[0] || !m_rr_last);
        e_we   = m_inflight && age == 1 && m_write && !rst;
        e_rsp0 = m_inflight && age == 3 && m_port == 0;
        e_rsp1 = m_inflight && age == 3 && m_port == 1;
        if (m_inflight && age == 3) m_exp_rdata[m_port] = m_write ? 16'h0 : m_rd;

        checkOutput("p0_req_ready", 32'(p0_req_ready), 32'(e_r0));
        checkOutput("p1_req_ready", 32'(p1_req_ready), 32'(e_r1));
        checkOutput("busy", 32'(busy), 32'(e_busy));
        checkOutput("ram_write_enable", 32'(ram_write_enable), 32'(e_we));
        checkOutput("p0_rsp_valid", 32'(p0_rsp_valid), 32'(e_rsp0));
        checkOutput("p1_rsp_valid", 32'(p1_rsp_valid), 32'(e_rsp1));
        checkOutput("p0_rsp_rdata", 32'(p0_rsp_rdata), 32'(m_exp_rdata[0]));
        checkOutput("p1_rsp_rdata", 32'(p1_rsp_rdata), 32'(m_exp_rdata[1]));
        checkOutput("ram_address", 32'(ram_address), 32'(m_ram_addr));
        checkOutput("ram_data_in", 32'(ram_data_in), 32'(m_ram_wdata));

        if (rst) begin
            m_inflight  = 1'b0;
            m_rr_last   = 1'b1;
            m_exp_rdata = '{16'h0, 16'h0};
            m_ram_addr  = 5'd0;
            m_ram_wdata = 16'h0;
        end else begin
            if (m_inflight && age == 1) begin
                if (m_write) ref_mem[m_addr] = m_wdata;
                else m_rd = ref_mem[m_addr];
            end
            if (m_inflight && age == 3) m_inflight = 1'b0;
            if (e_r0 || e_r1) begin
                p           = e_r1 ? 1 : 0;
                m_inflight  = 1'b1;
                m_acc       = cyc;
                m_port      = p;
                m_write     = hold_w[p];
                m_addr      = hold_a[p];
                m_wdata     = hold_d[p];
                m_rr_last   = e_r1;
                m_ram_addr  = hold_a[p];
                m_ram_wdata = hold_d[p];
                hold_v[p]   = 1'b0;
            end
        end
        cyc++;
    endtask

    // Directed scenarios first, then a long randomized stream with occasional resets and drops
    initial begin
        reset = 1'b1;
        p0_req_valid = 1'b0; p0_req_write = 1'b0; p0_req_addr = 5'd0; p0_req_wdata = 16'h0;
        p1_req_valid = 1'b0; p1_req_write = 1'b0; p1_req_addr = 5'd0; p1_req_wdata = 16'h0;
        hold_w = '{1'b0, 1'b0}; hold_a = '{5'd0, 5'd0}; hold_d = '{16'h0, 16'h0};

        for (int i = 0; i < 3; i++) applyStimulus(1'b1);

        setReq(0, 1'b0, 5'd0, 16'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0);

        setReq(0, 1'b1, 5'd5, 16'hBEEF);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0);
        setReq(1, 1'b0, 5'd5, 16'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0);

        for (int i = 0; i < 18; i++) begin
            if (!hold_v[0]) setReq(0, 1'b0, 5'd1, 16'h0);
            if (!hold_v[1]) setReq(1, 1'b0, 5'd2, 16'h0);
            applyStimulus(1'b0);
        end
        hold_v = '{1'b0, 1'b0};
        for (int i = 0; i < 4; i++) applyStimulus(1'b0);

        setReq(1, 1'b1, 5'd31, 16'hFFFF);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0);
        setReq(0, 1'b0, 5'd31, 16'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0);

        setReq(0, 1'b1, 5'd0, 16'hAAAA);
        applyStimulus(1'b0);
        setReq(0, 1'b0, 5'd0, 16'h0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0);

        setReq(0, 1'b0, 5'd3, 16'h0);
        applyStimulus(1'b0);
        setReq(1, 1'b1, 5'd3, 16'h1234);
        applyStimulus(1'b0);
        hold_v[1] = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0);

        for (int n = 0; n < 2000; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!hold_v[p]) begin
                    if ($urandom_range(0, 1) == 1)
                        setReq(p, 1'($urandom_range(0, 1)),
                               ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                               16'($urandom));
                end else if ($urandom_range(0, 15) == 0) begin
                    hold_v[p] = 1'b0;
                end
            end
            applyStimulus(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
